pdm_decoder: RTL

- Recovers a WIDTH-bit sample value from a 1-bit pulse-density-modulated stream. It is the receive end of the existing pdm modulator.
- Counts ones over a fixed window of 2^WIDTH enabled samples, saturates the count, and optionally smooths it with a first-order exponential filter.
- Used to read back PDM lines (loopback on pinbank pins, external sensors) and feed values to the LED matrix or the SPI register path.

---
 rtl/pdm_decoder.sv | 123 ++++++++++++
 1 files changed

// File: rtl/pdm_decoder.sv
// pdm_decoder: recovers a WIDTH-bit value from a 1-bit PDM stream by counting
// ones over 2^WIDTH enabled samples, with optional exponential smoothing.
`default_nettype none

module pdm_decoder #(
   parameter int WIDTH        = 10,
   parameter int SYNC_STAGES  = 2,
   parameter int SMOOTH_SHIFT = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic             en,
   input  logic             pdm_in,
   output logic [WIDTH-1:0] dout,
   output logic             dout_valid
);

   localparam logic [WIDTH-1:0] CNT_LAST = '1;

   logic s_bit;
   logic s_en;

   generate
      if (SYNC_STAGES == 0) begin : g_nosync
         assign s_bit = pdm_in;
         assign s_en  = en;
      end else begin : g_sync
         logic [SYNC_STAGES-1:0] bit_q;
         logic [SYNC_STAGES-1:0] en_q;

         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               bit_q <= '0;
               en_q  <= '0;
            end else begin
               bit_q[0] <= pdm_in;
               en_q[0]  <= en;
               for (int i = 1; i < SYNC_STAGES; i++) begin
                  bit_q[i] <= bit_q[i-1];
                  en_q[i]  <= en_q[i-1];
               end
            end
         end

         assign s_bit = bit_q[SYNC_STAGES-1];
         assign s_en  = en_q[SYNC_STAGES-1];
      end
   endgenerate

   logic [WIDTH-1:0] cnt_q;
   logic [WIDTH:0]   acc_q;
   logic [WIDTH:0]   raw;
   logic [WIDTH-1:0] result;
   logic [WIDTH-1:0] dout_d;
   logic             close;

   // raw can only reach 2^WIDTH on an all-ones window, so its top bit marks saturation
   assign raw    = acc_q + (WIDTH+1)'(s_bit);
   assign result = raw[WIDTH] ? {WIDTH{1'b1}} : raw[WIDTH-1:0];
   assign close  = s_en && (cnt_q == CNT_LAST);

   generate
      if (SMOOTH_SHIFT == 0) begin : g_nofilt
         assign dout_d = result;
      end else begin : g_filt
         localparam int YW = WIDTH + SMOOTH_SHIFT;

         logic [YW-1:0] yf_q;
         logic [YW-1:0] yf_d;
         logic          primed_q;

         // modular YW-bit arithmetic is exact because the true result always fits
         always_comb begin
            yf_d = {result, {SMOOTH_SHIFT{1'b0}}};
            if (primed_q) begin
               yf_d = yf_q + YW'(result) - (yf_q >> SMOOTH_SHIFT);
            end
         end

         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               yf_q     <= '0;
               primed_q <= 1'b0;
            end else if (clear) begin
               yf_q     <= '0;
               primed_q <= 1'b0;
            end else if (close) begin
               yf_q     <= yf_d;
               primed_q <= 1'b1;
            end
         end

         assign dout_d = yf_d[YW-1:SMOOTH_SHIFT];
      end
   endgenerate

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q      <= '0;
         acc_q      <= '0;
         dout       <= '0;
         dout_valid <= 1'b0;
      end else if (clear) begin
         cnt_q      <= '0;
         acc_q      <= '0;
         dout_valid <= 1'b0;
      end else begin
         dout_valid <= close;
         if (close) begin
            cnt_q <= '0;
            acc_q <= '0;
            dout  <= dout_d;
         end else if (s_en) begin
            cnt_q <= cnt_q + WIDTH'(1);
            acc_q <= raw;
         end
      end
   end

endmodule

`default_nettype wire
